// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner: synchronizes row returns, scans columns,
// debounces press/release and drives held level outputs for the calculator controller.
module keypad_scanner #(
    parameter int SCAN_DIV        = 16,
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       nRST,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic [3:0] keypad_out,
    output logic       operator_out,
    output logic       equal_out,
    output logic       clear_out,
    output logic       key_valid,
    output logic [3:0] key_code
);

    localparam int DW = $clog2(SCAN_DIV) + 1;
    localparam int BW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DWELL_ONE  = DW'(1);
    localparam logic [BW-1:0] DB_LAST    = BW'(DEBOUNCE_CYCLES - 1);
    localparam logic [BW-1:0] DB_MAX     = BW'(DEBOUNCE_CYCLES);
    localparam logic [BW-1:0] DB_ONE     = BW'(1);

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_PRESSED  = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    function automatic logic one_low(input logic [3:0] r);
        case (r)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: one_low = 1'b1;
            default:                            one_low = 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] low_idx(input logic [3:0] r);
        case (r)
            4'b1110: low_idx = 2'd0;
            4'b1101: low_idx = 2'd1;
            4'b1011: low_idx = 2'd2;
            4'b0111: low_idx = 2'd3;
            default: low_idx = 2'd0;
        endcase
    endfunction

    // Only digit positions map to a value; letters, '*' and '#' report idle on keypad_out.
    function automatic logic [3:0] digit_of(input logic [3:0] code);
        case (code)
            4'd0:    digit_of = 4'h1;
            4'd1:    digit_of = 4'h2;
            4'd2:    digit_of = 4'h3;
            4'd4:    digit_of = 4'h4;
            4'd5:    digit_of = 4'h5;
            4'd6:    digit_of = 4'h6;
            4'd8:    digit_of = 4'h7;
            4'd9:    digit_of = 4'h8;
            4'd10:   digit_of = 4'h9;
            4'd13:   digit_of = 4'h0;
            default: digit_of = 4'hF;
        endcase
    endfunction

    logic [3:0]    rows_meta_r, rows_sync_r, rows_s;
    state_t        state_r, state_s;
    logic [1:0]    col_idx_r, col_idx_s;
    logic [DW-1:0] dwell_r, dwell_s;
    logic [BW-1:0] db_r, db_s;
    logic [3:0]    key_r, key_s;
    logic [3:0]    pattern_r, pattern_s;
    logic          hold_s;
    logic [3:0]    cols_r, keypad_r, code_r;
    logic          operator_r, equal_r, clear_r, valid_r;

    assign rows_s = rows_sync_r;

    // Two-flop synchronizer for the asynchronous row returns.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            rows_meta_r <= 4'hF;
            rows_sync_r <= 4'hF;
        end else begin
            rows_meta_r <= rows;
            rows_sync_r <= rows_meta_r;
        end
    end

    // Next-state logic for scan, debounce, hold and release tracking.
    always_comb begin
        state_s   = state_r;
        col_idx_s = col_idx_r;
        dwell_s   = dwell_r;
        db_s      = db_r;
        key_s     = key_r;
        pattern_s = pattern_r;
        case (state_r)
            ST_SCAN: begin
                if (dwell_r >= DWELL_LAST) begin
                    dwell_s = '0;
                    if (one_low(rows_s)) begin
                        key_s     = {low_idx(rows_s), col_idx_r};
                        pattern_s = rows_s;
                        db_s      = '0;
                        state_s   = ST_DEBOUNCE;
                    end else begin
                        col_idx_s = col_idx_r + 2'd1;
                    end
                end else begin
                    dwell_s = dwell_r + DWELL_ONE;
                end
            end
            ST_DEBOUNCE: begin
                if (rows_s == pattern_r) begin
                    if (db_r >= DB_LAST) begin
                        db_s    = DB_MAX;
                        state_s = ST_PRESSED;
                    end else begin
                        db_s = db_r + DB_ONE;
                    end
                end else begin
                    db_s      = '0;
                    dwell_s   = '0;
                    col_idx_s = col_idx_r + 2'd1;
                    state_s   = ST_SCAN;
                end
            end
            ST_PRESSED: begin
                if (rows_s == 4'hF) begin
                    db_s    = '0;
                    state_s = ST_RELEASE;
                end else begin
                    state_s = ST_PRESSED;
                end
            end
            ST_RELEASE: begin
                if (rows_s == 4'hF) begin
                    if (db_r >= DB_LAST) begin
                        db_s      = '0;
                        dwell_s   = '0;
                        col_idx_s = col_idx_r + 2'd1;
                        state_s   = ST_SCAN;
                    end else begin
                        db_s = db_r + DB_ONE;
                    end
                end else begin
                    db_s    = '0;
                    state_s = ST_PRESSED;
                end
            end
            default: begin
                state_s   = ST_SCAN;
                col_idx_s = 2'd0;
                dwell_s   = '0;
                db_s      = '0;
            end
        endcase
        // Release clears outputs on the same edge that leaves RELEASE.
        hold_s = ((state_r == ST_PRESSED) || (state_r == ST_RELEASE)) && (state_s != ST_SCAN);
    end

    // State, counters, captured key and column drive.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_r   <= ST_SCAN;
            col_idx_r <= 2'd0;
            dwell_r   <= '0;
            db_r      <= '0;
            key_r     <= 4'd0;
            pattern_r <= 4'hF;
            cols_r    <= 4'b1110;
        end else begin
            state_r   <= state_s;
            col_idx_r <= col_idx_s;
            dwell_r   <= dwell_s;
            db_r      <= db_s;
            key_r     <= key_s;
            pattern_r <= pattern_s;
            cols_r    <= ~(4'b0001 << col_idx_s);
        end
    end

    // Registered level outputs toward the controller.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            keypad_r   <= 4'hF;
            operator_r <= 1'b0;
            equal_r    <= 1'b0;
            clear_r    <= 1'b0;
            valid_r    <= 1'b0;
            code_r     <= 4'd0;
        end else if (hold_s) begin
            keypad_r   <= digit_of(key_r);
            operator_r <= (key_r == 4'd3);
            equal_r    <= (key_r == 4'd14);
            clear_r    <= (key_r == 4'd15);
            valid_r    <= 1'b1;
            code_r     <= key_r;
        end else begin
            keypad_r   <= 4'hF;
            operator_r <= 1'b0;
            equal_r    <= 1'b0;
            clear_r    <= 1'b0;
            valid_r    <= 1'b0;
            code_r     <= 4'd0;
        end
    end

    assign cols         = cols_r;
    assign keypad_out   = keypad_r;
    assign operator_out = operator_r;
    assign equal_out    = equal_r;
    assign clear_out    = clear_r;
    assign key_valid    = valid_r;
    assign key_code     = code_r;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: a key-matrix model drives rows from cols,
// stimulus queues expected output bundles and a monitor checks every output change.
module tb_keypad_scanner;

    localparam int SCAN_DIV = 4;
    localparam int DB       = 8;
    localparam logic [11:0] IDLE = 12'hF00;

    logic        clk = 1'b0;
    logic        nRST = 1'b0;
    logic [15:0] pressed = 16'h0000;
    logic [3:0]  rows;
    logic [3:0]  cols, keypad_out, key_code;
    logic        operator_out, equal_out, clear_out, key_valid;

    int          checks = 0;
    int          errors = 0;
    logic [11:0] exp_q[$];
    logic [11:0] prev_b;
    bit          mon_en = 1'b0;
    logic [3:0]  col_seq [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    wire [11:0] bundle = {keypad_out, operator_out, equal_out, clear_out, key_valid, key_code};

    always #5 clk = ~clk;

    // Key matrix: a pressed key at {r,c} pulls row r low while column c is driven low.
    assign rows[0] = ~|(pressed[3:0]   & ~cols);
    assign rows[1] = ~|(pressed[7:4]   & ~cols);
    assign rows[2] = ~|(pressed[11:8]  & ~cols);
    assign rows[3] = ~|(pressed[15:12] & ~cols);

    keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CYCLES(DB)) dut (
        .clk(clk), .nRST(nRST), .rows(rows), .cols(cols),
        .keypad_out(keypad_out), .operator_out(operator_out), .equal_out(equal_out),
        .clear_out(clear_out), .key_valid(key_valid), .key_code(key_code)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_valid(input logic v, input int bound, output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (key_valid !== v && n < bound);
        if (key_valid !== v) begin
            checks++;
            errors++;
            $display("FAIL wait_key_valid_%0b: got %b after %0d cycles expected %b", v, key_valid, n, v);
        end
    endtask

    task automatic press_release(input int code, input logic [11:0] exp, input int hold);
        int n;
        exp_q.push_back(exp);
        pressed[code] = 1'b1;
        wait_valid(1'b1, 40, n);
        check("press_latency_le27", (n <= 27) ? 32'd1 : 32'd0, 32'd1);
        tick(hold);
        exp_q.push_back(IDLE);
        pressed[code] = 1'b0;
        wait_valid(1'b0, 40, n);
        check("release_latency", n, 32'd11);
    endtask

    // Monitor: every change of the output bundle must match the next queued expectation.
    always @(posedge clk) begin
        #1;
        if (mon_en && bundle !== prev_b) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got %h expected %h", bundle, prev_b);
            end else begin
                check("scoreboard", bundle, exp_q.pop_front());
            end
            prev_b = bundle;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        tick(2);
        check("reset_bundle", bundle, IDLE);
        check("reset_cols", cols, 4'b1110);
        prev_b = IDLE;
        mon_en = 1'b1;
        @(negedge clk);
        nRST = 1'b1;

        // Idle scan: column rotates every SCAN_DIV cycles.
        tick(1);
        for (int k = 0; k < 50; k++) begin
            check("idle_cols", cols, col_seq[k % 4]);
            tick(SCAN_DIV);
        end

        press_release(8, 12'h718, 100);    // '7'
        press_release(14, 12'hF5E, 30);    // '#'
        press_release(3, 12'hF93, 30);     // 'A'
        press_release(15, 12'hF3F, 30);    // 'D'
        press_release(7, 12'hF17, 30);     // 'B'

        // Bounce on '5', then stable press with a short high glitch.
        for (int b = 0; b < 5; b++) begin
            pressed[5] = 1'b1;
            tick(3);
            pressed[5] = 1'b0;
            tick(2);
        end
        check("bounce_no_output", bundle, IDLE);
        exp_q.push_back(12'h515);
        pressed[5] = 1'b1;
        wait_valid(1'b1, 40, n);
        check("bounce5_stable_ge8", (n >= DB) ? 32'd1 : 32'd0, 32'd1);
        tick(10);
        pressed[5] = 1'b0;
        tick(5);
        pressed[5] = 1'b1;
        tick(20);
        check("glitch_hold_5", keypad_out, 4'h5);
        exp_q.push_back(IDLE);
        pressed[5] = 1'b0;
        wait_valid(1'b0, 40, n);

        // Two rows on one column: rejected.
        pressed[0] = 1'b1;
        pressed[4] = 1'b1;
        tick(60);
        check("multi_row_reject", key_valid, 1'b0);
        pressed[0] = 1'b0;
        pressed[4] = 1'b0;
        tick(20);

        // '1' held, '9' added: stays 1 until both released.
        exp_q.push_back(12'h110);
        pressed[0] = 1'b1;
        wait_valid(1'b1, 40, n);
        tick(10);
        pressed[10] = 1'b1;
        tick(40);
        check("second_key_ignored", keypad_out, 4'h1);
        exp_q.push_back(IDLE);
        pressed[0] = 1'b0;
        pressed[10] = 1'b0;
        wait_valid(1'b0, 40, n);
        tick(20);

        // Reset mid-press of '3'.
        exp_q.push_back(12'h312);
        pressed[2] = 1'b1;
        wait_valid(1'b1, 40, n);
        tick(10);
        @(negedge clk);
        exp_q.push_back(IDLE);
        nRST = 1'b0;
        #1;
        check("async_reset_idle", bundle, IDLE);
        tick(3);
        @(negedge clk);
        exp_q.push_back(12'h312);
        nRST = 1'b1;
        wait_valid(1'b1, 40, n);
        check("redetect_latency_le27", (n <= 27) ? 32'd1 : 32'd0, 32'd1);
        check("redetect_3", keypad_out, 4'h3);
        exp_q.push_back(IDLE);
        pressed[2] = 1'b0;
        wait_valid(1'b0, 40, n);
        tick(5);

        check("queue_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
